alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Execute-issue stage directly upstream of the ALU. It holds the 32 x 64-bit architectural register file and accepts decoded operations over a valid/ready handshake. At accept time it reads operands, applying write-back bypass and immediate selection, and presents registered op1, op2 and ALU_Control to the ALU through a 2-entry skid buffer with its own valid/ready handshake.

Parameters:
DATA_W, 64, register/immediate width; ALU operand ports are DATA_W+1 bits wide.
NREGS, 32, register count; index NREGS-1 is the hard-wired zero register.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded op available
in_ready  out  1  stage can accept an op this cycle
in_rn  in  5  op1 source register index
in_rm  in  5  op2 source register index
in_imm  in  DATA_W  immediate value
in_use_imm  in  1  1 = op2 is in_imm, 0 = op2 is reg[in_rm]
in_alu_ctrl  in  4  ALU operation code
in_rd  in  5  destination index, carried through to the ALU side
wb_en  in  1  register write enable
wb_addr  in  5  write index
wb_data  in  DATA_W  write data
out_valid  out  1  op1/op2/ALU_Control/out_rd valid
out_ready  in  1  ALU side consumes the head entry
op1  out  DATA_W+1  operand 1, sign-extended by one bit
op2  out  DATA_W+1  operand 2, sign-extended by one bit
ALU_Control  out  4  operation code to the ALU
out_rd  out  5  destination index of the head entry
err_illegal  out  1  one-cycle pulse: an op with an illegal code was dropped

Behaviour:
- Legal ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS op2. All other codes are illegal.
- Reset (async, rst_n=0):
  - all registers cleared to 0;
  - buffer EMPTY; out_valid=0;
  - op1, op2, ALU_Control, out_rd all 0;
  - err_illegal=0; in_ready=0 while in reset.
  - Reset mid-operation discards all buffered entries.
- Buffer FSM:
  - States EMPTY, ONE, TWO.
  - in_ready=1 in EMPTY and ONE, 0 in TWO. in_ready is registered: a function of state only, never of out_ready.
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
  - EMPTY: accept goes to ONE.
  - ONE: accept with no pop goes to TWO; pop with no accept goes to EMPTY; accept with pop stays in ONE and the new entry becomes head next cycle.
  - TWO: pop goes to ONE, with the skid entry becoming head. No accept is possible.
  - out_valid = (state != EMPTY). Head outputs are driven from registers and stay stable while out_valid=1 and out_ready=0.
- Latency: an op accepted in cycle N appears at the outputs in cycle N+1 when the buffer was EMPTY, or when it was ONE and popped in the same cycle.
- Operand read, sampled at accept:
  - src(i) = 0 if i=31.
  - else src(i) = wb_data if wb_en & wb_addr==i (same-cycle bypass).
  - else src(i) = reg[i].
- Operand assembly:
  - op1 = {src(rn)[63], src(rn)}.
  - op2 = the same extension of (in_use_imm ? in_imm : src(rm)).
- Captured buffer entries are never refreshed by later write-backs.
- Write-back: on each clk edge with wb_en=1 and wb_addr!=31, reg[wb_addr] <= wb_data. Writes to index 31 are ignored. Write-back is independent of the handshake state.
- Illegal op:
  - When accepted, the op is not stored; state is unchanged.
  - err_illegal=1 in the following cycle only.
  - Back-to-back illegal accepts hold err_illegal high for consecutive cycles.

Test Plan:
- Reset then idle: check in_ready=0 during reset and in_ready=1 the first cycle after; out_valid, op1, op2 and ALU_Control all 0. Read of rn=5 with no prior write -> op1=0.
- Write-back then ADD: wb reg3=0x8000_0000_0000_0001, reg4=0x10. Issue ADD rn=3 rm=4 -> next cycle out_valid=1, op1=0x1_8000_0000_0000_0001, op2=0x10, ALU_Control=0010, out_rd=rd.
- Bypass and zero register:
  - Same cycle as accept, wb_en with reg7=0xAB; issue SUB rn=7 rm=31 -> op1=0xAB, op2=0.
  - wb_addr=31 with data 0xFF, then read rn=31 -> op1=0.
- Backpressure:
  - Hold out_ready=0 and issue three ops -> two accepted, in_ready=0 after the second, head outputs stable.
  - Release out_ready for 1 cycle -> first popped, second becomes head, in_ready=1.
- Immediate and illegal:
  - PASS with in_use_imm=1, imm=0x123 -> op2=0x123, ALU_Control=0111.
  - Code 0011 accepted -> not presented, err_illegal pulses exactly 1 cycle.
- Async reset mid-flight: assert rst_n=0 with buffer in TWO between clock edges -> out_valid=0 immediately, and the register file reads 0 after release.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
// Bundle for the ALU issue stage: the decoded-op input handshake, the
// write-back port into the register file, and the operand handshake towards
// the ALU.
//
//   Issue side : in_valid, in_ready, in_rn, in_rm, in_imm, in_use_imm,
//                in_alu_ctrl, in_rd
//   Write-back : wb_en, wb_addr, wb_data
//   ALU side   : out_valid, out_ready, op1, op2, ALU_Control, out_rd,
//                err_illegal
//
// Modports:
//   slave  - the issue stage itself
//   master - the environment (decoder, write-back path and ALU)
// -----------------------------------------------------------------------------
interface alu_issue_stage_if #(
    parameter int DATA_W = 64
);
    // Issue-side handshake
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rn;
    logic [4:0]        in_rm;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic [3:0]        in_alu_ctrl;
    logic [4:0]        in_rd;

    // Register-file write-back
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;

    // ALU-side handshake
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   op1;
    logic [DATA_W:0]   op2;
    logic [3:0]        ALU_Control;
    logic [4:0]        out_rd;
    logic              err_illegal;

    modport slave (
        input  in_valid, in_rn, in_rm, in_imm, in_use_imm, in_alu_ctrl, in_rd,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output in_ready,
        output out_valid, op1, op2, ALU_Control, out_rd, err_illegal
    );

    modport master (
        output in_valid, in_rn, in_rm, in_imm, in_use_imm, in_alu_ctrl, in_rd,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  in_ready,
        input  out_valid, op1, op2, ALU_Control, out_rd, err_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Execute-issue stage in front of the ALU. Holds the architectural register
// file, reads operands when a decoded op is accepted (with same-cycle
// write-back bypass and immediate selection) and hands registered
// op1/op2/ALU_Control/out_rd to the ALU through a 2-entry skid buffer.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_issue_stage_if.slave (issue handshake, write-back,
//            ALU handshake, err_illegal pulse)
//
// Parameters:
//   DATA_W - register / immediate width; ALU operands are DATA_W+1 bits
//   NREGS  - register count; index NREGS-1 always reads as zero
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
);

    localparam int             AW       = 5;
    localparam logic [AW-1:0]  ZERO_IDX = AW'(NREGS - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic is_legal(input logic [3:0] code);
        case (code)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASS: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    // One-bit sign extension so the ALU can see carry/borrow out of bit 63.
    function automatic logic signed [DATA_W:0] sext(input logic [DATA_W-1:0] v);
        return $signed({v[DATA_W-1], v});
    endfunction

    // Zero register wins over bypass; bypass wins over the stored value, so
    // an op issued in the same cycle as the write sees the new data.
    function automatic logic [DATA_W-1:0] read_src(
        input logic [AW-1:0]     idx,
        input logic [DATA_W-1:0] rf_val,
        input logic              wen,
        input logic [AW-1:0]     waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (idx == ZERO_IDX)
            return '0;
        else if (wen && (waddr == idx))
            return wdata;
        else
            return rf_val;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0]        r_regs [NREGS];

    state_t                   r_state;
    logic                     r_in_ready;
    logic                     r_vld_p1;
    logic                     r_err_p1;

    logic signed [DATA_W:0]   r_head_op1_p1;
    logic signed [DATA_W:0]   r_head_op2_p1;
    logic [3:0]               r_head_ctrl_p1;
    logic [4:0]               r_head_rd_p1;

    logic signed [DATA_W:0]   r_skid_op1_p1;
    logic signed [DATA_W:0]   r_skid_op2_p1;
    logic [3:0]               r_skid_ctrl_p1;
    logic [4:0]               r_skid_rd_p1;

    logic [DATA_W-1:0]        w_src_rn_p0;
    logic [DATA_W-1:0]        w_src_rm_p0;
    logic signed [DATA_W:0]   w_op1_p0;
    logic signed [DATA_W:0]   w_op2_p0;
    logic                     w_legal_p0;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_illegal;

    // -------------------------------------------------------------------------
    // p0: operand read and handshake decode at accept time
    // -------------------------------------------------------------------------
    always_comb begin
        w_src_rn_p0 = read_src(bus.in_rn, r_regs[bus.in_rn],
                               bus.wb_en, bus.wb_addr, bus.wb_data);
        w_src_rm_p0 = read_src(bus.in_rm, r_regs[bus.in_rm],
                               bus.wb_en, bus.wb_addr, bus.wb_data);
        w_op1_p0    = sext(w_src_rn_p0);
        w_op2_p0    = sext(bus.in_use_imm ? bus.in_imm : w_src_rm_p0);
        w_legal_p0  = is_legal(bus.in_alu_ctrl);
        w_accept    = bus.in_valid & r_in_ready;
        w_push      = w_accept & w_legal_p0;
        w_illegal   = w_accept & ~w_legal_p0;
        w_pop       = r_vld_p1 & bus.out_ready;
    end

    // -------------------------------------------------------------------------
    // Register file write-back, independent of the handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++)
                r_regs[k] <= '0;
        end else if (bus.wb_en && (bus.wb_addr != ZERO_IDX)) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // p1: skid buffer FSM with head/skid entries
    // in_ready is registered from the next state so it never depends
    // combinationally on out_ready. Illegal ops are dropped before the
    // buffer: they only raise err_illegal for one cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_EMPTY;
            r_in_ready     <= 1'b0;
            r_vld_p1       <= 1'b0;
            r_err_p1       <= 1'b0;
            r_head_op1_p1  <= '0;
            r_head_op2_p1  <= '0;
            r_head_ctrl_p1 <= '0;
            r_head_rd_p1   <= '0;
            r_skid_op1_p1  <= '0;
            r_skid_op2_p1  <= '0;
            r_skid_ctrl_p1 <= '0;
            r_skid_rd_p1   <= '0;
        end else begin
            r_err_p1 <= w_illegal;

            case (r_state)
                ST_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_push) begin
                        r_state        <= ST_ONE;
                        r_vld_p1       <= 1'b1;
                        r_head_op1_p1  <= w_op1_p0;
                        r_head_op2_p1  <= w_op2_p0;
                        r_head_ctrl_p1 <= bus.in_alu_ctrl;
                        r_head_rd_p1   <= bus.in_rd;
                    end
                end

                ST_ONE: begin
                    if (w_push && !w_pop) begin
                        // Head is stalled: park the new op in the skid slot.
                        r_state        <= ST_TWO;
                        r_in_ready     <= 1'b0;
                        r_skid_op1_p1  <= w_op1_p0;
                        r_skid_op2_p1  <= w_op2_p0;
                        r_skid_ctrl_p1 <= bus.in_alu_ctrl;
                        r_skid_rd_p1   <= bus.in_rd;
                    end else if (w_push && w_pop) begin
                        // Head leaves and the new op replaces it directly.
                        r_in_ready     <= 1'b1;
                        r_head_op1_p1  <= w_op1_p0;
                        r_head_op2_p1  <= w_op2_p0;
                        r_head_ctrl_p1 <= bus.in_alu_ctrl;
                        r_head_rd_p1   <= bus.in_rd;
                    end else if (w_pop) begin
                        r_state    <= ST_EMPTY;
                        r_in_ready <= 1'b1;
                        r_vld_p1   <= 1'b0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end

                ST_TWO: begin
                    if (w_pop) begin
                        r_state        <= ST_ONE;
                        r_in_ready     <= 1'b1;
                        r_head_op1_p1  <= r_skid_op1_p1;
                        r_head_op2_p1  <= r_skid_op2_p1;
                        r_head_ctrl_p1 <= r_skid_ctrl_p1;
                        r_head_rd_p1   <= r_skid_rd_p1;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                    r_vld_p1   <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all straight from registers
    // -------------------------------------------------------------------------
    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_vld_p1;
    assign bus.op1         = r_head_op1_p1;
    assign bus.op2         = r_head_op2_p1;
    assign bus.ALU_Control = r_head_ctrl_p1;
    assign bus.out_rd      = r_head_rd_p1;
    assign bus.err_illegal = r_err_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    alu_issue_stage_if #(.DATA_W(64)) bus ();

    alu_issue_stage #(.DATA_W(64), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [3:0] ctrl, input logic [4:0] rn,
                          input logic [4:0] rm, input logic [4:0] rd,
                          input logic use_imm, input logic [63:0] imm);
        bus.in_valid    = v;
        bus.in_alu_ctrl = ctrl;
        bus.in_rn       = rn;
        bus.in_rm       = rm;
        bus.in_rd       = rd;
        bus.in_use_imm  = use_imm;
        bus.in_imm      = imm;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] addr, input logic [63:0] data);
        bus.wb_en   = en;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        set_op(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        set_wb(1'b0, 5'd0, 64'h0);
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.op1 !== 65'h0 || bus.op2 !== 65'h0) $display("FAIL rst_ops got %h/%h exp 0/0", bus.op1, bus.op2); else n_pass++;
        n_total++; if (bus.ALU_Control !== 4'h0 || bus.out_rd !== 5'd0 || bus.err_illegal !== 1'b0)
            $display("FAIL rst_ctrl got %h/%h/%b exp 0/0/0", bus.ALU_Control, bus.out_rd, bus.err_illegal); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b exp 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL post_rst_out_valid got %b exp 0", bus.out_valid); else n_pass++;
        // Unwritten register reads as zero.
        set_op(1'b1, 4'b0000, 5'd5, 5'd5, 5'd1, 1'b0, 64'h0);
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.out_valid !== 1'b1 || bus.op1 !== 65'h0)
            $display("FAIL read_r5 got vld=%b op1=%h exp vld=1 op1=0", bus.out_valid, bus.op1); else n_pass++;
        pop_one();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL pop_empty got %b exp 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_wb_add();
        set_wb(1'b1, 5'd3, 64'h8000_0000_0000_0001);
        tick();
        set_wb(1'b1, 5'd4, 64'h10);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        set_op(1'b1, 4'b0010, 5'd3, 5'd4, 5'd9, 1'b0, 64'h0);
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL add_valid got %b exp 1", bus.out_valid); else n_pass++;
        n_total++; if (bus.op1 !== 65'h1_8000_0000_0000_0001) $display("FAIL add_op1 got %h exp 18000000000000001", bus.op1); else n_pass++;
        n_total++; if (bus.op2 !== 65'h10) $display("FAIL add_op2 got %h exp 10", bus.op2); else n_pass++;
        n_total++; if (bus.ALU_Control !== 4'b0010 || bus.out_rd !== 5'd9)
            $display("FAIL add_ctrl got %b/%0d exp 0010/9", bus.ALU_Control, bus.out_rd); else n_pass++;
        pop_one();
    endtask

    task automatic test_bypass_zero();
        // Write and read of reg7 in the same cycle.
        set_wb(1'b1, 5'd7, 64'hAB);
        set_op(1'b1, 4'b0110, 5'd7, 5'd31, 5'd2, 1'b0, 64'h0);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.op1 !== 65'hAB) $display("FAIL bypass_op1 got %h exp ab", bus.op1); else n_pass++;
        n_total++; if (bus.op2 !== 65'h0 || bus.ALU_Control !== 4'b0110)
            $display("FAIL bypass_op2 got %h/%b exp 0/0110", bus.op2, bus.ALU_Control); else n_pass++;
        pop_one();
        // Writes to r31 are dropped, even when bypass would match.
        set_wb(1'b1, 5'd31, 64'hFF);
        tick();
        set_op(1'b1, 4'b0000, 5'd31, 5'd31, 5'd3, 1'b0, 64'h0);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.out_valid !== 1'b1 || bus.op1 !== 65'h0 || bus.op2 !== 65'h0)
            $display("FAIL zero_reg got vld=%b op1=%h op2=%h exp 1/0/0", bus.out_valid, bus.op1, bus.op2); else n_pass++;
        pop_one();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_op(1'b1, 4'b0000, 5'd3, 5'd4, 5'd1, 1'b0, 64'h0);
        tick();
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_one got %b exp 1", bus.in_ready); else n_pass++;
        set_op(1'b1, 4'b0001, 5'd4, 5'd3, 5'd2, 1'b0, 64'h0);
        tick();
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_two got %b exp 0", bus.in_ready); else n_pass++;
        set_op(1'b1, 4'b0010, 5'd4, 5'd4, 5'd3, 1'b0, 64'h0);
        tick();
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd1 || bus.ALU_Control !== 4'b0000 ||
                      bus.op1 !== 65'h1_8000_0000_0000_0001 || bus.op2 !== 65'h10)
            $display("FAIL bp_head_stable got vld=%b rd=%0d ctrl=%b op1=%h op2=%h exp 1/1/0000/18000000000000001/10",
                     bus.out_valid, bus.out_rd, bus.ALU_Control, bus.op1, bus.op2); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_held got %b exp 0", bus.in_ready); else n_pass++;
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        pop_one();
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd2 || bus.ALU_Control !== 4'b0001 ||
                      bus.op1 !== 65'h10 || bus.op2 !== 65'h1_8000_0000_0000_0001)
            $display("FAIL bp_skid_head got vld=%b rd=%0d ctrl=%b op1=%h op2=%h exp 1/2/0001/10/18000000000000001",
                     bus.out_valid, bus.out_rd, bus.ALU_Control, bus.op1, bus.op2); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after_pop got %b exp 1", bus.in_ready); else n_pass++;
        // Accept and pop together in ONE: new op is head next cycle.
        set_op(1'b1, 4'b0010, 5'd31, 5'd4, 5'd3, 1'b0, 64'h0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd3 || bus.op1 !== 65'h0 || bus.op2 !== 65'h10)
            $display("FAIL bp_acc_pop got vld=%b rd=%0d op1=%h op2=%h exp 1/3/0/10",
                     bus.out_valid, bus.out_rd, bus.op1, bus.op2); else n_pass++;
        pop_one();
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", bus.out_valid); else n_pass++;
        // A captured entry keeps its operand after a later write-back.
        set_op(1'b1, 4'b0000, 5'd4, 5'd4, 5'd4, 1'b0, 64'h0);
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        set_wb(1'b1, 5'd4, 64'h55);
        tick();
        set_wb(1'b0, 5'd0, 64'h0);
        n_total++; if (bus.op1 !== 65'h10) $display("FAIL no_refresh got %h exp 10", bus.op1); else n_pass++;
        pop_one();
    endtask

    task automatic test_imm_illegal();
        set_op(1'b1, 4'b0111, 5'd3, 5'd4, 5'd5, 1'b1, 64'h123);
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.op2 !== 65'h123 || bus.ALU_Control !== 4'b0111)
            $display("FAIL imm_pass got %h/%b exp 123/0111", bus.op2, bus.ALU_Control); else n_pass++;
        pop_one();
        set_op(1'b1, 4'b0111, 5'd31, 5'd4, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.op2 !== 65'h1_FFFF_FFFF_FFFF_FFF0) $display("FAIL imm_neg got %h exp 1fffffffffffffff0", bus.op2); else n_pass++;
        pop_one();
        set_op(1'b1, 4'b0011, 5'd3, 5'd4, 5'd7, 1'b0, 64'h0);
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.err_illegal !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL illegal_pulse got err=%b vld=%b exp 1/0", bus.err_illegal, bus.out_valid); else n_pass++;
        tick();
        n_total++; if (bus.err_illegal !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL illegal_end got err=%b vld=%b exp 0/0", bus.err_illegal, bus.out_valid); else n_pass++;
        set_op(1'b1, 4'b1111, 5'd3, 5'd4, 5'd7, 1'b0, 64'h0);
        tick();
        n_total++; if (bus.err_illegal !== 1'b1) $display("FAIL illegal_b2b_1 got %b exp 1", bus.err_illegal); else n_pass++;
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.err_illegal !== 1'b1 || bus.in_ready !== 1'b1)
            $display("FAIL illegal_b2b_2 got err=%b rdy=%b exp 1/1", bus.err_illegal, bus.in_ready); else n_pass++;
        tick();
        n_total++; if (bus.err_illegal !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL illegal_b2b_end got err=%b vld=%b exp 0/0", bus.err_illegal, bus.out_valid); else n_pass++;
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        set_op(1'b1, 4'b0010, 5'd3, 5'd4, 5'd1, 1'b0, 64'h0);
        tick();
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            $display("FAIL ar_fill got vld=%b rdy=%b exp 1/0", bus.out_valid, bus.in_ready); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.out_valid !== 1'b0 || bus.op1 !== 65'h0 || bus.out_rd !== 5'd0)
            $display("FAIL ar_immediate got vld=%b op1=%h rd=%0d exp 0/0/0", bus.out_valid, bus.op1, bus.out_rd); else n_pass++;
        tick();
        rst_n = 1'b1;
        set_op(1'b1, 4'b0010, 5'd3, 5'd4, 5'd8, 1'b0, 64'h0);
        tick();
        n_total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL ar_release got rdy=%b vld=%b exp 1/0", bus.in_ready, bus.out_valid); else n_pass++;
        tick();
        set_op(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 64'h0);
        n_total++; if (bus.out_valid !== 1'b1 || bus.op1 !== 65'h0 || bus.op2 !== 65'h0 || bus.out_rd !== 5'd8)
            $display("FAIL ar_rf_cleared got vld=%b op1=%h op2=%h rd=%0d exp 1/0/0/8",
                     bus.out_valid, bus.op1, bus.op2, bus.out_rd); else n_pass++;
        pop_one();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_wb_add();
        test_bypass_zero();
        test_backpressure();
        test_imm_illegal();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
